ahb_split_slave_mc: RTL and testbench

Multi-master AHB slave that answers every first-time access with a two-cycle SPLIT response and tracks each split master independently. Each master gets its own delay counter; the slave releases that master with a one-cycle HSPLIT pulse and completes its retried access with zero wait states from an internal word memory. The block sits on the AHB slave side of the bus matrix next to the arbiter, which consumes HSPLIT.

---
 rtl/ahb_pkg.sv | 32 +++
 rtl/ahb_split_slave_mc_if.sv | 32 +++
 rtl/ahb_split_tracker.sv | 66 ++++++
 rtl/ahb_split_slave_mc.sv | 134 +++++++++++++
 tb/tb_ahb_split_slave_mc.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB encodings plus the state types used by the split slave and its trackers.
package ahb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY   = 2'b01,
        NONSEQ = 2'b10,
        SEQ    = 2'b11
    } htrans_t;

    typedef enum logic [1:0] {
        OKAY  = 2'b00,
        ERROR = 2'b01,
        RETRY = 2'b10,
        SPLIT = 2'b11
    } hresp_t;

    typedef enum logic [1:0] {
        T_FREE,
        T_WAIT,
        T_READY
    } trk_state_t;

    typedef enum logic [2:0] {
        R_IDLE,
        R_SPL1,
        R_SPL2,
        R_ERR1,
        R_ERR2
    } rsp_state_t;

endpackage

// File: rtl/ahb_split_slave_mc_if.sv
// AHB slave-side bus bundle for ahb_split_slave_mc; HREADY is the bus-level ready from the matrix.
interface ahb_split_slave_mc_if
    import ahb_pkg::*;
#(
    parameter int NUM_MASTERS = 16,
    parameter int ADDR_W      = 32
);
    localparam int MID_W = $clog2(NUM_MASTERS);

    logic                   HSEL;
    logic [ADDR_W-1:0]      HADDR;
    htrans_t                HTRANS;
    logic                   HWRITE;
    logic [31:0]            HWDATA;
    logic                   HREADY;
    logic [MID_W-1:0]       HMASTER;
    logic                   HREADYOUT;
    hresp_t                 HRESP;
    logic [31:0]            HRDATA;
    logic [NUM_MASTERS-1:0] HSPLIT;

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HWDATA, HREADY, HMASTER,
        output HREADYOUT, HRESP, HRDATA, HSPLIT
    );

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HWDATA, HREADY, HMASTER,
        input  HREADYOUT, HRESP, HRDATA, HSPLIT
    );

endinterface

// File: rtl/ahb_split_tracker.sv
// Per-master split tracker: counts SPLIT_DELAY cycles after a split, then pulses hsplit once
// and holds READY until the master's retry completes.
module ahb_split_tracker
    import ahb_pkg::*;
#(
    parameter int SPLIT_DELAY = 5
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       start_i,
    input  logic       hit_i,
    output trk_state_t state_o,
    output logic       hsplit_o
);
    localparam int CNT_W = $clog2(SPLIT_DELAY + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SPLIT_DELAY);

    trk_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             hsplit_q, hsplit_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= T_FREE;
            cnt_q    <= '0;
            hsplit_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hsplit_q <= hsplit_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hsplit_d = 1'b0;
        unique case (state_q)
            T_FREE: begin
                if (start_i) begin
                    state_d = T_WAIT;
                    cnt_d   = '0;
                end
            end
            // A repeated request while waiting does not restart the count.
            T_WAIT: begin
                if (cnt_q == CNT_MAX) begin
                    state_d  = T_READY;
                    hsplit_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            T_READY: begin
                if (hit_i) begin
                    state_d = T_FREE;
                end
            end
            default: state_d = T_FREE;
        endcase
    end

    assign state_o  = state_q;
    assign hsplit_o = hsplit_q;

endmodule

// File: rtl/ahb_split_slave_mc.sv
// Multi-master AHB split slave backed by a word memory; optional out-of-range ERROR
// responses are enabled by defining AHB_SPLIT_ERR_EN.
module ahb_split_slave_mc
    import ahb_pkg::*;
#(
    parameter int NUM_MASTERS = 16,
    parameter int SPLIT_DELAY = 5,
    parameter int MEM_DEPTH   = 64,
    parameter int ADDR_W      = 32
) (
    input  logic                 HCLK,
    input  logic                 HRESETn,
    ahb_split_slave_mc_if.slave  bus
);
    localparam int IDX_W = $clog2(MEM_DEPTH);
    localparam int MID_W = $clog2(NUM_MASTERS);

    rsp_state_t       rsp_q, rsp_d;
    logic             rdPend_q, rdPend_d;
    logic             wrPend_q, wrPend_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [31:0]      mem_q [MEM_DEPTH];

    trk_state_t             trkState [NUM_MASTERS];
    trk_state_t             curState;
    logic [NUM_MASTERS-1:0] start, hit, hsplit;
    logic                   accept, addrErr, doSplit, doOkay, doErr;
    logic                   unusedAddr;

    // The first cycle of a two-cycle response never carries a new address phase.
    assign accept = bus.HSEL && bus.HREADY
                    && (bus.HTRANS == NONSEQ || bus.HTRANS == SEQ)
                    && rsp_q != R_SPL1 && rsp_q != R_ERR1;

`ifdef AHB_SPLIT_ERR_EN
    assign addrErr = bus.HADDR >= ADDR_W'(4 * MEM_DEPTH);
`else
    assign addrErr = 1'b0;
`endif

    assign unusedAddr = ^{bus.HADDR[ADDR_W-1:IDX_W+2], bus.HADDR[1:0]};

    always_comb begin
        curState = T_FREE;
        for (int m = 0; m < NUM_MASTERS; m++) begin
            if (bus.HMASTER == MID_W'(m)) begin
                curState = trkState[m];
            end
        end
    end

    assign doSplit = accept && !addrErr && curState != T_READY;
    assign doOkay  = accept && !addrErr && curState == T_READY;
    assign doErr   = accept && addrErr;

    for (genvar m = 0; m < NUM_MASTERS; m++) begin : g_trk
        assign start[m] = doSplit && bus.HMASTER == MID_W'(m) && trkState[m] == T_FREE;
        assign hit[m]   = doOkay && bus.HMASTER == MID_W'(m);

        ahb_split_tracker #(
            .SPLIT_DELAY (SPLIT_DELAY)
        ) u_trk (
            .clk_i    (HCLK),
            .rst_ni   (HRESETn),
            .start_i  (start[m]),
            .hit_i    (hit[m]),
            .state_o  (trkState[m]),
            .hsplit_o (hsplit[m])
        );
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            rsp_q    <= R_IDLE;
            rdPend_q <= 1'b0;
            wrPend_q <= 1'b0;
            idx_q    <= '0;
        end else begin
            rsp_q    <= rsp_d;
            rdPend_q <= rdPend_d;
            wrPend_q <= wrPend_d;
            idx_q    <= idx_d;
        end
    end

    always_comb begin
        rsp_d    = R_IDLE;
        rdPend_d = 1'b0;
        wrPend_d = 1'b0;
        idx_d    = idx_q;
        if (rsp_q == R_SPL1) begin
            rsp_d = R_SPL2;
        end else if (rsp_q == R_ERR1) begin
            rsp_d = R_ERR2;
        end else if (doSplit) begin
            rsp_d = R_SPL1;
        end else if (doErr) begin
            rsp_d = R_ERR1;
        end else if (doOkay) begin
            rdPend_d = !bus.HWRITE;
            wrPend_d = bus.HWRITE;
            idx_d    = bus.HADDR[IDX_W+1:2];
        end
    end

    always_comb begin
        bus.HREADYOUT = 1'b1;
        bus.HRESP     = OKAY;
        unique case (rsp_q)
            R_SPL1: begin
                bus.HREADYOUT = 1'b0;
                bus.HRESP     = SPLIT;
            end
            R_SPL2: bus.HRESP = SPLIT;
            R_ERR1: begin
                bus.HREADYOUT = 1'b0;
                bus.HRESP     = ERROR;
            end
            R_ERR2: bus.HRESP = ERROR;
            default: ;
        endcase
    end

    // Memory is deliberately left out of reset; its contents are undefined after reset.
    always_ff @(posedge HCLK) begin
        if (wrPend_q) begin
            mem_q[idx_q] <= bus.HWDATA;
        end
    end

    assign bus.HRDATA = rdPend_q ? mem_q[idx_q] : 32'h0;
    assign bus.HSPLIT = hsplit;

endmodule

// File: tb/tb_ahb_split_slave_mc.sv
// Directed bench for ahb_split_slave_mc: split/release timing, retries, re-request,
// mid-operation reset, IDLE/BUSY and the out-of-range path (AHB_SPLIT_ERR_EN).
module tb_ahb_split_slave_mc;
    import ahb_pkg::*;

    localparam int NUM_MASTERS = 16;
    localparam int SPLIT_DELAY = 5;
    localparam int MEM_DEPTH   = 64;
    localparam int ADDR_W      = 32;

    logic HCLK = 1'b0;
    logic HRESETn = 1'b0;
    int   checkCount = 0;
    int   passCount  = 0;

    always #5 HCLK = ~HCLK;

    ahb_split_slave_mc_if #(.NUM_MASTERS(NUM_MASTERS), .ADDR_W(ADDR_W)) busIf ();

    // Single slave on the bus, so bus-level HREADY follows this slave's HREADYOUT.
    assign busIf.HREADY = busIf.HREADYOUT;

    ahb_split_slave_mc #(
        .NUM_MASTERS (NUM_MASTERS),
        .SPLIT_DELAY (SPLIT_DELAY),
        .MEM_DEPTH   (MEM_DEPTH),
        .ADDR_W      (ADDR_W)
    ) dut (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .bus     (busIf)
    );

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) tick();
    endtask

    task automatic applyStimulus(input logic sel, input htrans_t trans, input logic wr,
                                 input int mst, input logic [31:0] addr);
        busIf.HSEL    = sel;
        busIf.HTRANS  = trans;
        busIf.HWRITE  = wr;
        busIf.HMASTER = 4'(mst);
        busIf.HADDR   = addr;
    endtask

    task automatic idleBus();
        applyStimulus(1'b0, IDLE, 1'b0, 0, 32'h0);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic checkResp(input string tag, input logic rdy, input hresp_t resp);
        checkOutput({tag, "_rdy"}, 32'(busIf.HREADYOUT), 32'(rdy));
        checkOutput({tag, "_resp"}, 32'(busIf.HRESP), 32'(resp));
    endtask

    task automatic checkSplit(input string tag, input logic [15:0] exp);
        checkOutput(tag, 32'(busIf.HSPLIT), 32'(exp));
    endtask

    initial begin
        idleBus();
        busIf.HWDATA = 32'h0;
        waitCycles(2);
        checkResp("rst", 1'b1, OKAY);
        checkOutput("rst_rdata", busIf.HRDATA, 32'h0);
        checkSplit("rst_hsplit", 16'h0000);
        HRESETn = 1'b1;
        tick();

        // Master 2 write: split, release at N+7, zero-wait retry.
        applyStimulus(1'b1, NONSEQ, 1'b1, 2, 32'h10);
        tick();
        idleBus();
        checkResp("m2w_spl1", 1'b0, SPLIT);
        tick();
        checkResp("m2w_spl2", 1'b1, SPLIT);
        checkSplit("m2w_hs_n2", 16'h0000);
        waitCycles(4);
        checkSplit("m2w_hs_n6", 16'h0000);
        tick();
        checkSplit("m2w_hs_n7", 16'h0004);
        applyStimulus(1'b1, NONSEQ, 1'b1, 2, 32'h10);
        tick();
        idleBus();
        busIf.HWDATA = 32'hA5A5_0001;
        checkResp("m2w_ok", 1'b1, OKAY);
        checkSplit("m2w_hs_n8", 16'h0000);
        tick();

        // Master 2 read-back through a fresh split.
        applyStimulus(1'b1, NONSEQ, 1'b0, 2, 32'h10);
        tick();
        idleBus();
        busIf.HWDATA = 32'h0;
        checkResp("m2r_spl1", 1'b0, SPLIT);
        tick();
        checkResp("m2r_spl2", 1'b1, SPLIT);
        waitCycles(5);
        checkSplit("m2r_hs", 16'h0004);
        applyStimulus(1'b1, NONSEQ, 1'b0, 2, 32'h10);
        tick();
        idleBus();
        checkResp("m2r_ok", 1'b1, OKAY);
        checkOutput("m2r_rdata", busIf.HRDATA, 32'hA5A5_0001);
        tick();
        checkOutput("m2r_rdata_idle", busIf.HRDATA, 32'h0);

        // Masters 1 and 3 split on consecutive acceptable address phases.
        applyStimulus(1'b1, NONSEQ, 1'b0, 1, 32'h20);
        tick();
        idleBus();
        checkResp("m1_spl1", 1'b0, SPLIT);
        tick();
        applyStimulus(1'b1, NONSEQ, 1'b0, 3, 32'h24);
        checkResp("m1_spl2", 1'b1, SPLIT);
        tick();
        idleBus();
        checkResp("m3_spl1", 1'b0, SPLIT);
        tick();
        checkResp("m3_spl2", 1'b1, SPLIT);
        waitCycles(3);
        checkSplit("m1_hs", 16'h0002);
        tick();
        checkSplit("m13_hs_gap", 16'h0000);
        tick();
        checkSplit("m3_hs", 16'h0008);
        applyStimulus(1'b1, NONSEQ, 1'b0, 1, 32'h20);
        tick();
        checkResp("m1_ok", 1'b1, OKAY);
        checkSplit("m3_hs_after", 16'h0000);
        applyStimulus(1'b1, NONSEQ, 1'b0, 3, 32'h24);
        tick();
        idleBus();
        checkResp("m3_ok", 1'b1, OKAY);
        tick();

        // Master 4 re-requests at cnt=2; release time is unchanged and pulses once.
        applyStimulus(1'b1, NONSEQ, 1'b1, 4, 32'h30);
        tick();
        idleBus();
        checkResp("m4_spl1", 1'b0, SPLIT);
        waitCycles(2);
        applyStimulus(1'b1, NONSEQ, 1'b1, 4, 32'h30);
        tick();
        idleBus();
        checkResp("m4_re_spl1", 1'b0, SPLIT);
        tick();
        checkResp("m4_re_spl2", 1'b1, SPLIT);
        tick();
        checkSplit("m4_hs_b6", 16'h0000);
        tick();
        checkSplit("m4_hs_b7", 16'h0010);
        for (int i = 0; i < 6; i++) begin
            tick();
            checkSplit("m4_hs_once", 16'h0000);
        end
        applyStimulus(1'b1, NONSEQ, 1'b1, 4, 32'h30);
        tick();
        idleBus();
        busIf.HWDATA = 32'h1234_5678;
        checkResp("m4_ok", 1'b1, OKAY);
        tick();

        // IDLE and BUSY are zero-wait OKAY and leave master 6 FREE.
        applyStimulus(1'b1, IDLE, 1'b0, 6, 32'h40);
        tick();
        checkResp("idle", 1'b1, OKAY);
        applyStimulus(1'b1, BUSY, 1'b0, 6, 32'h40);
        tick();
        checkResp("busy", 1'b1, OKAY);
        applyStimulus(1'b1, NONSEQ, 1'b0, 6, 32'h40);
        tick();
        idleBus();
        checkResp("m6_spl1", 1'b0, SPLIT);
        tick();

        // Reset while masters 5 and 6 are waiting discards both releases.
        applyStimulus(1'b1, NONSEQ, 1'b0, 5, 32'h44);
        tick();
        idleBus();
        checkResp("m5_spl1", 1'b0, SPLIT);
        HRESETn = 1'b0;
        #1;
        checkResp("midrst", 1'b1, OKAY);
        checkOutput("midrst_rdata", busIf.HRDATA, 32'h0);
        checkSplit("midrst_hsplit", 16'h0000);
        waitCycles(2);
        HRESETn = 1'b1;
        for (int i = 0; i < SPLIT_DELAY + 4; i++) begin
            tick();
            checkSplit("postrst_hs", 16'h0000);
        end
        applyStimulus(1'b1, NONSEQ, 1'b0, 5, 32'h44);
        tick();
        idleBus();
        checkResp("m5_free_spl1", 1'b0, SPLIT);
        waitCycles(7);

        // Address 0x100 is beyond the 64-word memory.
        applyStimulus(1'b1, NONSEQ, 1'b0, 7, 32'h100);
        tick();
        idleBus();
`ifdef AHB_SPLIT_ERR_EN
        checkResp("oor_err1", 1'b0, ERROR);
        tick();
        checkResp("oor_err2", 1'b1, ERROR);
        for (int i = 0; i < SPLIT_DELAY + 2; i++) begin
            tick();
            checkSplit("oor_hs", 16'h0000);
        end
`else
        checkResp("wrap_spl1", 1'b0, SPLIT);
        tick();
        checkResp("wrap_spl2", 1'b1, SPLIT);
        waitCycles(5);
        checkSplit("wrap_hs", 16'h0080);
`endif
        tick();

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
